alu_reservation_station: RTL

- Consumer end of the common data bus: buffers dispatched ALU instructions, snoops CDB broadcasts to capture missing operands, and issues ready instructions to the ALU.
- Sits between the dispatch stage and the ALU.
- Honours the CDB arbiter's alu_stall back-pressure: the CDB gives the memory unit priority, and while alu_stall is high the ALU cannot retire, so issue must hold.

---
 rtl/alu_reservation_station_if.sv | 53 +++++
 rtl/alu_reservation_station.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station_if.sv
// ---------------------------------------------------------------------------
// alu_reservation_station_if
// Groups the dispatch, common-data-bus, back-pressure and issue signals of the
// ALU reservation station.
//   master : environment side (dispatch stage, CDB, CDB arbiter, ALU)
//   slave  : reservation station side
// Ports carried:
//   disp_valid/disp_ready handshake, disp_op, disp_dest_tag,
//   disp_src{1,2}_{rdy,tag,val}    dispatched instruction
//   cdb_valid, cdb_tag, cdb_data    result broadcast
//   alu_stall                       ALU must hold its current instruction
//   iss_valid, iss_op, iss_src1, iss_src2, iss_dest_tag  issue register
// ---------------------------------------------------------------------------
interface alu_reservation_station_if #(
  parameter int TAG_W = 6,
  parameter int OP_W  = 6
);
  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             disp_src1_rdy;
  logic [TAG_W-1:0] disp_src1_tag;
  logic [31:0]      disp_src1_val;
  logic             disp_src2_rdy;
  logic [TAG_W-1:0] disp_src2_tag;
  logic [31:0]      disp_src2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             alu_stall;
  logic             iss_valid;
  logic [OP_W-1:0]  iss_op;
  logic [31:0]      iss_src1;
  logic [31:0]      iss_src2;
  logic [TAG_W-1:0] iss_dest_tag;

  modport master (
    output disp_valid, disp_op, disp_dest_tag,
    output disp_src1_rdy, disp_src1_tag, disp_src1_val,
    output disp_src2_rdy, disp_src2_tag, disp_src2_val,
    output cdb_valid, cdb_tag, cdb_data, alu_stall,
    input  disp_ready, iss_valid, iss_op, iss_src1, iss_src2, iss_dest_tag
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest_tag,
    input  disp_src1_rdy, disp_src1_tag, disp_src1_val,
    input  disp_src2_rdy, disp_src2_tag, disp_src2_val,
    input  cdb_valid, cdb_tag, cdb_data, alu_stall,
    output disp_ready, iss_valid, iss_op, iss_src1, iss_src2, iss_dest_tag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
// Buffers dispatched ALU instructions, snoops CDB broadcasts to capture
// missing operands and issues the lowest-index ready entry into a single
// issue register that holds while the CDB arbiter stalls the ALU.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (clears entries and issue register)
//   flush  synchronous clear of entries and issue register
//   rs     alu_reservation_station_if.slave (dispatch, CDB, stall, issue)
// ---------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int OP_W  = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  alu_reservation_station_if.slave rs
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int DATA_W = 32;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  s1_rdy;
  logic [DEPTH-1:0]  s2_rdy;
  logic [OP_W-1:0]   op_q     [DEPTH];
  logic [TAG_W-1:0]  dest_q   [DEPTH];
  logic [TAG_W-1:0]  s1_tag   [DEPTH];
  logic [TAG_W-1:0]  s2_tag   [DEPTH];
  logic [DATA_W-1:0] s1_val   [DEPTH];
  logic [DATA_W-1:0] s2_val   [DEPTH];

  logic              vld_p1;
  logic [OP_W-1:0]   iss_op_p1;
  logic [TAG_W-1:0]  iss_dest_p1;
  logic [DATA_W-1:0] iss_src1_p1;
  logic [DATA_W-1:0] iss_src2_p1;

  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_free;
  logic              any_elig;
  logic              advance;
  logic              do_disp;
  logic              d_s1_wake;
  logic              d_s2_wake;

  // A source waits on a tag; a valid broadcast of that exact tag supplies it.
  function automatic logic wakes(input logic rdy, input logic [TAG_W-1:0] tag,
                                 input logic cv, input logic [TAG_W-1:0] ct);
    return !rdy && cv && (tag == ct);
  endfunction

  // Priority pick on registered state only: scanning from the top lets the
  // lowest index win, and an operand captured this cycle is not yet visible.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
      if (busy[i] && s1_rdy[i] && s2_rdy[i]) begin
        sel_idx  = IDX_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign advance   = !rs.alu_stall || !vld_p1;
  assign do_disp   = rs.disp_valid && any_free;
  assign d_s1_wake = wakes(rs.disp_src1_rdy, rs.disp_src1_tag, rs.cdb_valid, rs.cdb_tag);
  assign d_s2_wake = wakes(rs.disp_src2_rdy, rs.disp_src2_tag, rs.cdb_valid, rs.cdb_tag);

  // ---- stage p0: entry array (dispatch write, CDB capture) / stage p1: issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      s1_rdy      <= '0;
      s2_rdy      <= '0;
      vld_p1      <= 1'b0;
      iss_op_p1   <= '0;
      iss_dest_p1 <= '0;
      iss_src1_p1 <= '0;
      iss_src2_p1 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        s1_tag[i] <= '0;
        s2_tag[i] <= '0;
        s1_val[i] <= '0;
        s2_val[i] <= '0;
      end
    end else if (flush) begin
      busy        <= '0;
      s1_rdy      <= '0;
      s2_rdy      <= '0;
      vld_p1      <= 1'b0;
      iss_op_p1   <= '0;
      iss_dest_p1 <= '0;
      iss_src1_p1 <= '0;
      iss_src2_p1 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && wakes(s1_rdy[i], s1_tag[i], rs.cdb_valid, rs.cdb_tag)) begin
          s1_rdy[i] <= 1'b1;
          s1_val[i] <= rs.cdb_data;
        end
        if (busy[i] && wakes(s2_rdy[i], s2_tag[i], rs.cdb_valid, rs.cdb_tag)) begin
          s2_rdy[i] <= 1'b1;
          s2_val[i] <= rs.cdb_data;
        end
      end

      // The selected entry is busy and the dispatch target is free, so the
      // two writes below never touch the same slot.
      if (advance) begin
        vld_p1 <= any_elig;
        if (any_elig) begin
          busy[sel_idx] <= 1'b0;
          iss_op_p1     <= op_q[sel_idx];
          iss_dest_p1   <= dest_q[sel_idx];
          iss_src1_p1   <= s1_val[sel_idx];
          iss_src2_p1   <= s2_val[sel_idx];
        end
      end

      if (do_disp) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= rs.disp_op;
        dest_q[free_idx] <= rs.disp_dest_tag;
        s1_tag[free_idx] <= rs.disp_src1_tag;
        s2_tag[free_idx] <= rs.disp_src2_tag;
        s1_rdy[free_idx] <= rs.disp_src1_rdy || d_s1_wake;
        s2_rdy[free_idx] <= rs.disp_src2_rdy || d_s2_wake;
        s1_val[free_idx] <= d_s1_wake ? rs.cdb_data : rs.disp_src1_val;
        s2_val[free_idx] <= d_s2_wake ? rs.cdb_data : rs.disp_src2_val;
      end
    end
  end

  assign rs.disp_ready   = any_free;
  assign rs.iss_valid    = vld_p1;
  assign rs.iss_op       = iss_op_p1;
  assign rs.iss_dest_tag = iss_dest_p1;
  assign rs.iss_src1     = iss_src1_p1;
  assign rs.iss_src2     = iss_src2_p1;

endmodule
